footswitch_sequencer: RTL and testbench
=======================================

FOOTSWITCH_SEQUENCER -- requirements
Module: footswitch_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: audio sample width, signed two's complement.
REQ-002 SHALL have parameter FADE_LOG2, default 6: fade length is 2^FADE_LOG2 samples per ramp direction.
REQ-003 SHALL have parameter DEBOUNCE_SAMPLES, default 480: number of stable sample ticks required (10 ms at 48 kHz).
REQ-004 SHALL have port clk_i, input, 1: single clock.
REQ-005 SHALL have port srst_i, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port sample_tick_i, input, 1: one-clock strobe per audio sample.
REQ-007 SHALL have port button_i, input, 3: raw footswitches; [0] left, [1] side toggle (level), [2] right.
REQ-008 SHALL have port data_i, input, DATA_WIDTH: chain output sample, valid on sample_tick_i.
REQ-009 SHALL have port data_o, output, DATA_WIDTH: faded sample.
REQ-010 SHALL have port left_en_o, output, 1: left effect group enable.
REQ-011 SHALL have port right_en_o, output, 1: right effect group enable.
REQ-012 SHALL have port side_toggle_o, output, 1: debounced button_i[1] level.
REQ-013 SHALL have port busy_o, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL pass each button_i bit through a 2-flop synchroniser before any other logic.
REQ-015 SHALL raise a left or right toggle request on a rising edge of the debounced button[0] or button[2] respectively; falling edges SHALL be ignored.
REQ-016 SHALL latch requests into pending_l/pending_r by XOR, so two presses before the swap cancel each other.
REQ-017 SHALL implement FSM IDLE -> FADE_OUT -> SWAP -> FADE_IN -> IDLE.
REQ-018 In IDLE, SHALL go to FADE_OUT when any pending bit is set; gain SHALL equal 2^FADE_LOG2, i.e. unity.
REQ-019 In FADE_OUT, gain SHALL decrement by 1 per sample_tick_i and SHALL go to SWAP on the clock after gain reaches 0.
REQ-020 SWAP SHALL last exactly one clock: left_en_o ^= pending_l, right_en_o ^= pending_r, pending cleared, then go to FADE_IN.
REQ-021 In FADE_IN, gain SHALL increment by 1 per tick and SHALL go to IDLE once gain reaches 2^FADE_LOG2.
REQ-022 Requests arriving in FADE_OUT SHALL be merged into the current swap; requests arriving in FADE_IN SHALL stay pending and start a new cycle from IDLE.
REQ-023 If pending is all-zero at SWAP, enables SHALL be unchanged and the fade-in SHALL still complete.
REQ-024 gain SHALL be FADE_LOG2+1 bits and saturate at 0 and at 2^FADE_LOG2, never wrapping.
REQ-025 data_o SHALL register (data_i * gain) >>> FADE_LOG2 (arithmetic shift), computed full-width then truncated, one clock after sample_tick_i; it SHALL hold between ticks.
REQ-026 At unity gain, data_o SHALL equal data_i bit-exactly.
REQ-027 side_toggle_o SHALL follow the debounced button_i[1] with no fade.

Reset
REQ-028 On srst_i, outputs SHALL be data_o=0, left_en_o=0, right_en_o=0, side_toggle_o=0 and busy_o=0; FSM SHALL be IDLE, gain unity, pending cleared, and debounce counters and stable states cleared.
REQ-029 Reset asserted mid-fade SHALL abort immediately to the reset state with no swap applied.

Configuration
REQ-030 With macro FOOTSWITCH_DEBOUNCE_EN defined, a debounced bit SHALL change only after the synchronised input differs from it for DEBOUNCE_SAMPLES consecutive sample ticks; the counter SHALL reset on any mismatch-free tick.
REQ-031 Without FOOTSWITCH_DEBOUNCE_EN, the debounced bit SHALL equal the synchroniser output and the counters SHALL be absent.

Structure
REQ-032 The FSM state enum and the button index constants (BTN_LEFT=0, BTN_SIDE=1, BTN_RIGHT=2) SHALL live in main_config.
REQ-033 A single sub-module, button_debouncer (one bit, instantiated 3 times), SHALL contain the synchroniser and the debounce logic.

Verification
REQ-034 Scenario: macro on, button_i[2] held high for 479 ticks then released -> no request, right_en_o=0.
REQ-035 Scenario: button_i[2] held 600 ticks, FADE_LOG2=6, data_i=16'h4000 -> gain steps 64..0, right_en_o=1 at SWAP, data_o returns to 16'h4000 after 128 ticks; busy_o high throughout.
REQ-036 Scenario: left pressed twice during FADE_OUT -> left_en_o unchanged after SWAP.
REQ-037 Scenario: right pressed during FADE_IN -> second full cycle follows IDLE, right_en_o toggles twice in total.
REQ-038 Scenario: data_i=16'h8000 at gain 32 -> data_o=16'hC000 (sign preserved).
REQ-039 Scenario: srst_i pulsed at gain 10 in FADE_OUT -> next clock: IDLE, gain 64, enables 0, data_o 0.

Source files
------------

// File: rtl/main_config.sv
// -----------------------------------------------------------------------------
// main_config
// Shared definitions for the footswitch sequencer:
//   - fsm_state_t  : crossfade FSM states (IDLE -> FADE_OUT -> SWAP -> FADE_IN)
//   - BTN_LEFT / BTN_SIDE / BTN_RIGHT : bit positions within button_i
//   - NUM_BUTTONS  : number of raw footswitch inputs
// -----------------------------------------------------------------------------
package main_config;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWAP     = 2'd2,
        ST_FADE_IN  = 2'd3
    } fsm_state_t;

    localparam int BTN_LEFT    = 0;
    localparam int BTN_SIDE    = 1;
    localparam int BTN_RIGHT   = 2;
    localparam int NUM_BUTTONS = 3;

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// One footswitch bit: 2-flop synchroniser followed by an optional
// sample-tick-based debouncer.
//
// Build option: FOOTSWITCH_DEBOUNCE_EN
//   defined   : the output changes only after the synchronised input has
//               differed from it on DEBOUNCE_SAMPLES consecutive sample ticks.
//   undefined : the output is the synchroniser output; no counter exists.
//
// Ports:
//   clk          in  clock
//   srst         in  synchronous active-high reset
//   sample_tick  in  one-clock strobe per audio sample
//   button       in  raw (asynchronous) footswitch level
//   debounced    out cleaned level
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_SAMPLES = 480
) (
    input  logic clk,
    input  logic srst,
    input  logic sample_tick,
    input  logic button,
    output logic debounced
);

    logic sync1_reg;
    logic sync2_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= button;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef FOOTSWITCH_DEBOUNCE_EN
    // Counter only needs to reach DEBOUNCE_SAMPLES-1: the final mismatching
    // tick commits the new level instead of incrementing.
    localparam int CNT_W = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SAMPLES - 1);

    logic [CNT_W-1:0] count_reg;
    logic             stable_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg  <= '0;
            stable_reg <= 1'b0;
        end else if (sample_tick) begin
            if (sync2_reg != stable_reg) begin
                if (count_reg == CNT_LAST) begin
                    stable_reg <= sync2_reg;
                    count_reg  <= '0;
                end else begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end else begin
                // Any tick that agrees with the stable level restarts the run.
                count_reg <= '0;
            end
        end
    end

    assign debounced = stable_reg;
`else
    logic unused_tick;
    assign unused_tick = sample_tick ^ (DEBOUNCE_SAMPLES == 0);
    assign debounced   = sync2_reg;
`endif

endmodule

// File: rtl/footswitch_sequencer.sv
// -----------------------------------------------------------------------------
// footswitch_sequencer
// Footswitch-driven effect group switcher with a click-free gain crossfade.
// Left/right presses (rising edges) are collected as pending toggles; the
// audio is faded to silence, the enables are swapped while silent, then the
// audio is faded back to unity.
//
// Build option: FOOTSWITCH_DEBOUNCE_EN (see button_debouncer).
//
// Ports:
//   clk_i          in  clock
//   srst_i         in  synchronous active-high reset
//   sample_tick_i  in  one-clock strobe per audio sample
//   button_i[2:0]  in  raw footswitches: [0] left, [1] side level, [2] right
//   data_i         in  signed audio sample, valid with sample_tick_i
//   data_o         out faded sample, updated one clock after each tick
//   left_en_o      out left effect group enable
//   right_en_o     out right effect group enable
//   side_toggle_o  out debounced side switch level
//   busy_o         out high while a fade/swap sequence is in progress
// -----------------------------------------------------------------------------
module footswitch_sequencer
    import main_config::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int FADE_LOG2        = 6,
    parameter int DEBOUNCE_SAMPLES = 480
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic                   sample_tick_i,
    input  logic [NUM_BUTTONS-1:0] button_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   left_en_o,
    output logic                   right_en_o,
    output logic                   side_toggle_o,
    output logic                   busy_o
);

    localparam int GAIN_W = FADE_LOG2 + 1;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = {1'b1, {FADE_LOG2{1'b0}}};
    // data (signed) times gain (non-negative, one extra sign bit) fits exactly.
    localparam int PROD_W = DATA_WIDTH + GAIN_W + 1;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [NUM_BUTTONS-1:0] debounced;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
        ) u_debouncer (
            .clk         (clk_i),
            .srst        (srst_i),
            .sample_tick (sample_tick_i),
            .button      (button_i[gi]),
            .debounced   (debounced[gi])
        );
    end

    logic deb_prev_l_reg;
    logic deb_prev_r_reg;
    logic req_l;
    logic req_r;

    // Only presses (rising edges) request a toggle; releases are ignored.
    assign req_l = debounced[BTN_LEFT]  & ~deb_prev_l_reg;
    assign req_r = debounced[BTN_RIGHT] & ~deb_prev_r_reg;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            deb_prev_l_reg <= 1'b0;
            deb_prev_r_reg <= 1'b0;
        end else begin
            deb_prev_l_reg <= debounced[BTN_LEFT];
            deb_prev_r_reg <= debounced[BTN_RIGHT];
        end
    end

    assign side_toggle_o = debounced[BTN_SIDE];

    // ------------------------------------------------------------------
    // Crossfade FSM
    // ------------------------------------------------------------------
    fsm_state_t        state_reg;
    fsm_state_t        state_next;
    logic [GAIN_W-1:0] gain_reg;
    logic              pending_l_reg;
    logic              pending_r_reg;
    logic              left_en_reg;
    logic              right_en_reg;
    logic              swap_en;
    logic              gain_dec;
    logic              gain_inc;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pending_l_reg || pending_r_reg) begin
                    state_next = ST_FADE_OUT;
                end
            end
            ST_FADE_OUT: begin
                if (gain_reg == '0) begin
                    state_next = ST_SWAP;
                end
            end
            ST_SWAP: begin
                state_next = ST_FADE_IN;
            end
            ST_FADE_IN: begin
                if (gain_reg == GAIN_UNITY) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o   = (state_reg != ST_IDLE);
        swap_en  = (state_reg == ST_SWAP);
        gain_dec = (state_reg == ST_FADE_OUT) && sample_tick_i && (gain_reg != '0);
        gain_inc = (state_reg == ST_FADE_IN) && sample_tick_i && (gain_reg != GAIN_UNITY);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            gain_reg <= GAIN_UNITY;
        end else if (state_reg == ST_IDLE) begin
            gain_reg <= GAIN_UNITY;
        end else if (gain_dec) begin
            gain_reg <= gain_reg - GAIN_W'(1);
        end else if (gain_inc) begin
            gain_reg <= gain_reg + GAIN_W'(1);
        end
    end

    // Pending bits accumulate by XOR so a double press cancels. A press
    // landing exactly on the SWAP clock is kept for the next cycle.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pending_l_reg <= 1'b0;
            pending_r_reg <= 1'b0;
            left_en_reg   <= 1'b0;
            right_en_reg  <= 1'b0;
        end else if (swap_en) begin
            left_en_reg   <= left_en_reg  ^ pending_l_reg;
            right_en_reg  <= right_en_reg ^ pending_r_reg;
            pending_l_reg <= req_l;
            pending_r_reg <= req_r;
        end else begin
            pending_l_reg <= pending_l_reg ^ req_l;
            pending_r_reg <= pending_r_reg ^ req_r;
        end
    end

    assign left_en_o  = left_en_reg;
    assign right_en_o = right_en_reg;

    // ------------------------------------------------------------------
    // Gain stage
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] scaled;
    logic [DATA_WIDTH-1:0]    data_reg;
    logic                     unused_scaled_hi;

    assign data_ext = PROD_W'($signed(data_i));
    assign gain_ext = PROD_W'({1'b0, gain_reg});
    assign product  = data_ext * gain_ext;
    // Arithmetic shift keeps the sign; at unity the shift undoes the multiply.
    assign scaled   = product >>> FADE_LOG2;
    assign unused_scaled_hi = ^scaled[PROD_W-1:DATA_WIDTH];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            data_reg <= '0;
        end else if (sample_tick_i) begin
            data_reg <= scaled[DATA_WIDTH-1:0];
        end
    end

    assign data_o = data_reg;

endmodule

// File: tb/tb_footswitch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_footswitch_sequencer
// Self-checking bench for footswitch_sequencer. A behavioural model written
// from the sequencing rules (integer gain, phase number, pending toggles)
// predicts every output on every clock; directed scenarios add fixed
// expectations for the press/fade/swap corner cases. Works with or without
// FOOTSWITCH_DEBOUNCE_EN. DEBOUNCE_SAMPLES is shortened so double presses
// fit inside a single fade.
// -----------------------------------------------------------------------------
module tb_footswitch_sequencer;

    localparam int DW    = 16;
    localparam int FL    = 6;
    localparam int DEB   = 16;
    localparam int UNITY = 64;
    localparam int P_IDLE = 0;
    localparam int P_OUT  = 1;
    localparam int P_SWAP = 2;
    localparam int P_IN   = 3;
`ifdef FOOTSWITCH_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          srst;
    logic          sample_tick;
    logic [2:0]    button;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          left_en;
    logic          right_en;
    logic          side_toggle;
    logic          busy;

    always #5 clk = ~clk;

    footswitch_sequencer #(
        .DATA_WIDTH       (DW),
        .FADE_LOG2        (FL),
        .DEBOUNCE_SAMPLES (DEB)
    ) dut (
        .clk_i         (clk),
        .srst_i        (srst),
        .sample_tick_i (sample_tick),
        .button_i      (button),
        .data_i        (data_in),
        .data_o        (data_out),
        .left_en_o     (left_en),
        .right_en_o    (right_en),
        .side_toggle_o (side_toggle),
        .busy_o        (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [2:0]      m_s1, m_s2, m_stable, m_prev;
    int            m_run [3];
    bit            m_pl, m_pr, m_el, m_er;
    int            m_gain;
    int            m_phase;
    logic [DW-1:0] m_dout;

    function automatic bit [2:0] m_deb();
        if (DEB_ON) return m_stable;
        return m_s2;
    endfunction

    function automatic logic [31:0] model_outs();
        bit [2:0] d;
        d = m_deb();
        return {12'd0, m_dout, m_el, m_er, d[1], (m_phase != P_IDLE)};
    endfunction

    task automatic model_step(input bit tick, input bit [2:0] btn, input logic [DW-1:0] din, input bit rst);
        bit [2:0] d;
        bit rl, rr;
        int old_phase, prod;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
            for (int b = 0; b < 3; b++) m_run[b] = 0;
            m_pl = 0; m_pr = 0; m_el = 0; m_er = 0;
            m_gain = UNITY; m_phase = P_IDLE; m_dout = '0;
            return;
        end
        d  = m_deb();
        rl = d[0] && !m_prev[0];
        rr = d[2] && !m_prev[2];
        m_prev = d;
        if (tick) begin
            prod   = $signed(din) * m_gain;
            prod   = prod >>> FL;
            m_dout = prod[DW-1:0];
        end
        old_phase = m_phase;
        case (m_phase)
            P_IDLE: begin
                m_gain = UNITY;
                if (m_pl || m_pr) m_phase = P_OUT;
            end
            P_OUT: begin
                if (m_gain == 0) m_phase = P_SWAP;
                else if (tick) m_gain--;
            end
            P_SWAP: begin
                m_el ^= m_pl;
                m_er ^= m_pr;
                m_phase = P_IN;
            end
            default: begin
                if (m_gain == UNITY) m_phase = P_IDLE;
                else if (tick) m_gain++;
            end
        endcase
        if (old_phase == P_SWAP) begin
            m_pl = rl; m_pr = rr;
        end else begin
            m_pl ^= rl; m_pr ^= rr;
        end
        if (DEB_ON && tick) begin
            for (int b = 0; b < 3; b++) begin
                if (m_s2[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_stable[b] = m_s2[b];
                        m_run[b]    = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    // ---------------- stimulus / monitors ----------------
    bit            din_fixed = 0;
    logic [DW-1:0] din_val   = '0;
    bit            want_c000 = 0;
    bit            want_rst  = 0;
    bit            mon_last_r, mon_last_l, mon_last_busy;
    int            mon_tog_r, mon_tog_l, mon_busy_rise, mon_min;

    task automatic mon_clear();
        mon_last_r    = right_en;
        mon_last_l    = left_en;
        mon_last_busy = busy;
        mon_tog_r     = 0;
        mon_tog_l     = 0;
        mon_busy_rise = 0;
        mon_min       = 65535;
    endtask

    task automatic step_clk(input bit tick, input bit [2:0] btn, input bit rst);
        logic [DW-1:0] din;
        @(negedge clk);
        check("outs", {12'd0, data_out, left_en, right_en, side_toggle, busy}, model_outs());
        if (want_c000) begin
            check("neg_half", {16'd0, data_out}, 32'h0000_C000);
            want_c000 = 0;
        end
        if (want_rst) begin
            check("post_rst", {12'd0, data_out, left_en, right_en, side_toggle, busy}, 32'd0);
            want_rst = 0;
        end
        if (right_en !== mon_last_r) mon_tog_r++;
        if (left_en !== mon_last_l) mon_tog_l++;
        if (busy && !mon_last_busy) mon_busy_rise++;
        if (int'(data_out) < mon_min) mon_min = int'(data_out);
        mon_last_r    = right_en;
        mon_last_l    = left_en;
        mon_last_busy = busy;

        din       = din_fixed ? din_val : DW'($urandom);
        want_c000 = tick && !rst && (din == 16'h8000) && (m_gain == 32);
        want_rst  = rst;
        srst        = rst;
        sample_tick = tick;
        button      = btn;
        data_in     = din;
        model_step(tick, btn, din, rst);
    endtask

    // gap < 0 : random 0..2 idle clocks between ticks
    task automatic run_ticks(input int n, input bit [2:0] btn, input int gap);
        int g;
        for (int t = 0; t < n; t++) begin
            step_clk(1'b1, btn, 1'b0);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) step_clk(1'b0, btn, 1'b0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_r;
        bit exp_l;
        int waited;
        srst = 1'b1; sample_tick = 1'b0; button = '0; data_in = '0;
        model_step(1'b0, 3'b000, '0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", {12'd0, data_out, left_en, right_en, side_toggle, busy}, 32'd0);
        mon_clear();

        // A: right held one tick short of the debounce length
        run_ticks(DEB - 1, 3'b100, 1);
        run_ticks(200, 3'b000, 1);
        exp_r = DEB_ON ? 1'b0 : 1'b1;
        check("short_hold_r", {31'd0, right_en}, {31'd0, exp_r});
        check("short_hold_busy", {31'd0, busy}, 32'd0);
        $display("scenario short_hold: checks=%0d failures=%0d", checks, failures);

        // B: long right hold with constant 0x4000 input
        din_fixed = 1; din_val = 16'h4000;
        mon_clear();
        run_ticks(600, 3'b100, 1);
        run_ticks(40, 3'b000, 1);
        exp_r = !exp_r;
        check("long_hold_r", {31'd0, right_en}, {31'd0, exp_r});
        check("long_hold_data", {16'd0, data_out}, 32'h0000_4000);
        check("long_hold_busy", {31'd0, busy}, 32'd0);
        check("long_hold_busy_rises", mon_busy_rise, 1);
        check("long_hold_min", mon_min, 0);
        din_fixed = 0;
        $display("scenario long_hold: checks=%0d failures=%0d", checks, failures);

        // C: left pressed twice during fade-out, right once
        exp_l = 1'b0;
        mon_clear();
        run_ticks(4, 3'b100, 1);
        run_ticks(32, 3'b101, 1);
        run_ticks(22, 3'b100, 1);
        run_ticks(30, 3'b101, 1);
        run_ticks(200, 3'b000, 1);
        exp_r = !exp_r;
        check("dbl_left_l", {31'd0, left_en}, {31'd0, exp_l});
        check("dbl_left_r", {31'd0, right_en}, {31'd0, exp_r});
        check("dbl_left_tog_l", mon_tog_l, 0);
        check("dbl_left_busy", {31'd0, busy}, 32'd0);
        $display("scenario double_left: checks=%0d failures=%0d", checks, failures);

        // D: right pressed again during fade-in -> two full cycles
        mon_clear();
        run_ticks(40, 3'b100, 1);
        run_ticks(60, 3'b000, 1);
        run_ticks(30, 3'b100, 1);
        run_ticks(300, 3'b000, 1);
        check("fadein_tog_r", mon_tog_r, 2);
        check("fadein_r", {31'd0, right_en}, {31'd0, exp_r});
        check("fadein_busy_rises", mon_busy_rise, 2);
        $display("scenario fadein_press: checks=%0d failures=%0d", checks, failures);

        // E: negative full-scale input through the fade, side switch held
        din_fixed = 1; din_val = 16'h8000;
        run_ticks(30, 3'b011, 1);
        check("side_on", {31'd0, side_toggle}, 32'd1);
        run_ticks(200, 3'b000, 1);
        exp_l = 1'b1;
        check("neg_left", {31'd0, left_en}, {31'd0, exp_l});
        check("side_off", {31'd0, side_toggle}, 32'd0);
        din_fixed = 0;
        $display("scenario negative_fade: checks=%0d failures=%0d", checks, failures);

        // F: reset in the middle of a fade-out
        run_ticks(20, 3'b001, 1);
        waited = 0;
        while (!(m_phase == P_OUT && m_gain == 10) && waited < 3000) begin
            step_clk(1'($urandom_range(0, 1)), 3'b000, 1'b0);
            waited++;
        end
        check("g10_reached", {31'd0, (waited < 3000)}, 32'd1);
        step_clk(1'b0, 3'b000, 1'b1);
        run_ticks(10, 3'b000, 1);
        check("rst_mid_l", {31'd0, left_en}, 32'd0);
        check("rst_mid_r", {31'd0, right_en}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        $display("scenario mid_fade_reset: checks=%0d failures=%0d", checks, failures);

        // G: random presses, data, tick spacing and occasional reset
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 39) == 0) step_clk(1'b0, 3'b000, 1'b1);
            run_ticks(int'($urandom_range(1, 40)), 3'($urandom_range(0, 7)), -1);
        end
        run_ticks(300, 3'b000, -1);
        step_clk(1'b0, 3'b000, 1'b0);
        $display("scenario random: checks=%0d failures=%0d", checks, failures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
